// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory byte port, redirect input and
// instruction delivery handshake toward the decoder.
// master = fetch unit side, slave = memory/decoder/branch environment.
interface fetch_unit_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [7:0]  mem_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] instruction;
    logic [31:0] PC;
    logic        fetch_err;

    modport master (
        output mem_req, mem_addr, inst_valid, instruction, PC, fetch_err,
        input  mem_data, redirect, redirect_pc, inst_ready
    );

    modport slave (
        input  mem_req, mem_addr, inst_valid, instruction, PC, fetch_err,
        output mem_data, redirect, redirect_pc, inst_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Byte-serial instruction fetch unit.
// Issues four byte reads per instruction (one per cycle), assembles them
// big-endian and presents the word with its PC until the decoder accepts it.
// Redirects restart fetching at redirect_pc and discard in-flight bytes.
// Optional macro FETCH_ALIGN_CHECK_EN: a redirect to a non word-aligned
// address parks the unit in an error state with fetch_err raised.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic          clk,
    input logic          rst_n,
    fetch_unit_if.master bus
);

`ifdef FETCH_ALIGN_CHECK_EN
    typedef enum logic [1:0] {ISSUE, DRAIN, HOLD, ERR} state_t;
`else
    typedef enum logic [1:0] {ISSUE, DRAIN, HOLD} state_t;
`endif

    state_t      state;
    logic [1:0]  cnt;        // byte index of the request issued this cycle
    logic [31:0] pc;         // address of the instruction being fetched/held
    logic [23:0] bytes_q;    // most recent three returned bytes, oldest on top
    logic [31:0] instr_q;    // instruction output register
    logic        pending;    // a byte for the current fetch returns this cycle
    logic        valid_q;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        err_q;
    logic        redirect_bad;

    // Misaligned redirect targets are rejected rather than fetched.
    always_comb begin
        redirect_bad = (bus.redirect_pc[1:0] != 2'b00);
    end
`endif

    // Fetch FSM: request sequencing, byte assembly and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ISSUE;
            cnt     <= '0;
            pc      <= RESET_PC;
            bytes_q <= '0;
            instr_q <= '0;
            pending <= 1'b0;
            valid_q <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            // Only bytes answering requests of the current fetch are kept;
            // stale ones from before a redirect/reset arrive with pending=0.
            if (pending) begin
                bytes_q <= {bytes_q[15:0], bus.mem_data};
            end

            if (bus.redirect) begin
                pc      <= bus.redirect_pc;
                cnt     <= '0;
                pending <= 1'b0;
                valid_q <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
                if (redirect_bad) begin
                    state <= ERR;
                    err_q <= 1'b1;
                end else begin
                    state <= ISSUE;
                    err_q <= 1'b0;
                end
`else
                state   <= ISSUE;
`endif
            end else begin
                unique case (state)
                    ISSUE: begin
                        pending <= 1'b1;
                        cnt     <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            state <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        // Last byte arrives now; publish the whole word at once.
                        pending <= 1'b0;
                        instr_q <= {bytes_q, bus.mem_data};
                        valid_q <= 1'b1;
                        state   <= HOLD;
                    end
                    HOLD: begin
                        if (bus.inst_ready) begin
                            pc      <= pc + 32'd4;
                            valid_q <= 1'b0;
                            state   <= ISSUE;
                        end
                    end
`ifdef FETCH_ALIGN_CHECK_EN
                    ERR: begin
                        state <= ERR;
                    end
`endif
                    default: begin
                        state <= ISSUE;
                    end
                endcase
            end
        end
    end

    // Requests are gated by rst_n so the first one goes out in the cycle
    // reset is released and none is made while reset is held.
    assign bus.mem_req     = rst_n & (state == ISSUE);
    assign bus.mem_addr    = pc + {30'd0, cnt};
    assign bus.inst_valid  = valid_q;
    assign bus.instruction = instr_q;
    assign bus.PC          = pc;
`ifdef FETCH_ALIGN_CHECK_EN
    assign bus.fetch_err   = err_q;
`else
    assign bus.fetch_err   = 1'b0;
`endif

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the byte address of the first instruction fetched after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 mem_req  output  1  byte read request to instruction memory.
REQ-005 mem_addr  output  32  byte address of the request; valid when mem_req=1.
REQ-006 mem_data  input  8  read byte, valid exactly one cycle after the accepted request, in issue order.
REQ-007 redirect  input  1  branch/jump request; single-cycle pulse or level.
REQ-008 redirect_pc  input  32  new byte address; sampled when redirect=1.
REQ-009 inst_valid  output  1  instruction and PC hold a complete instruction.
REQ-010 inst_ready  input  1  decoder accepts instruction; handshake = inst_valid & inst_ready.
REQ-011 instruction  output  32  assembled instruction word.
REQ-012 PC  output  32  byte address of the instruction on the instruction output.
REQ-013 fetch_err  output  1  misaligned redirect flag (Configuration).

Function
REQ-014 The FSM SHALL have states ISSUE (byte counter 0..3), DRAIN, HOLD, and ERR (macro builds only).
- ISSUE: one request per cycle, mem_addr = PC + cnt (mod 2^32).
- Transitions: cnt 3 -> DRAIN; last byte captured -> HOLD; handshake in HOLD -> ISSUE cnt 0 with PC = PC + 4 (mod 2^32).
REQ-015 Byte ordering SHALL be big-endian: byte at PC+0 -> instruction[31:24], PC+1 -> [23:16], PC+2 -> [15:8], PC+3 -> [7:0].
REQ-016 Latency SHALL be fixed: byte0 request in cycle N, inst_valid high in cycle N+5; the next byte0 request is in the cycle after the handshake.
REQ-017 inst_valid SHALL be 1 only in HOLD; instruction and PC SHALL remain stable while inst_valid=1 and inst_ready=0.
REQ-018 mem_req SHALL be 0 in DRAIN, HOLD and ERR.
REQ-019 redirect=1 in any state SHALL apply as follows.
- Next cycle: PC = redirect_pc, state ISSUE cnt 0, inst_valid = 0.
- Bytes returning from requests issued before the redirect SHALL be discarded.
REQ-020 redirect and handshake in the same cycle: the instruction counts as consumed; redirect takes priority over PC+4.
REQ-021 Partially assembled instruction bytes SHALL never be visible on instruction while inst_valid=0; the output register updates only on entry to HOLD.
REQ-022 PC+4 from 32'hFFFF_FFFC SHALL wrap to 32'h0000_0000; byte addresses within one fetch wrap likewise.

Reset
REQ-023 While rst_n=0, outputs SHALL be:
- mem_req=0, mem_addr=RESET_PC, inst_valid=0, instruction=0, PC=RESET_PC, fetch_err=0.
- FSM state ISSUE, cnt 0; the first request is in the first clock after rst_n rises.
REQ-024 Assertion of rst_n mid-fetch SHALL abort the fetch immediately; bytes arriving after reset release from pre-reset requests SHALL be ignored.

Configuration
REQ-025 Macro FETCH_ALIGN_CHECK_EN SHALL control misaligned-redirect checking.
- Defined: redirect with redirect_pc[1:0]!=0 enters ERR.
  - In ERR: fetch_err=1, inst_valid=0, mem_req=0, PC=redirect_pc.
  - ERR persists until reset or an aligned redirect, which clears fetch_err and resumes ISSUE.
- Not defined: fetch_err tied 0; unaligned redirect_pc fetched normally byte-by-byte from that address.

Verification
REQ-026 Reset release, RESET_PC=0, memory bytes 00..07 = 20 08 00 05 8C 09 00 04, inst_ready=1 -> first word 32'h2008_0005 at PC=0 in cycle 5, then 32'h8C09_0004 at PC=4.
REQ-027 inst_ready=0 for 10 cycles in HOLD -> inst_valid, instruction and PC unchanged and mem_req=0 throughout; fetch resumes one cycle after inst_ready=1.
REQ-028 redirect to 32'h40 during ISSUE cnt 2 -> in-flight bytes dropped, next request mem_addr=32'h40, delivered PC=32'h40 with bytes from 40..43.
REQ-029 redirect and handshake in the same cycle, redirect_pc=32'h80 -> next delivered PC is 32'h80, not old PC+4.
REQ-030 RESET_PC=32'hFFFF_FFFC -> first fetch addresses FFFF_FFFC..FFFF_FFFF, next PC=32'h0.
REQ-031 FETCH_ALIGN_CHECK_EN defined, redirect_pc=32'h42 -> fetch_err=1, mem_req=0; then redirect_pc=32'h44 -> fetch_err=0, fetch from 32'h44. Macro undefined, same stimulus -> fetch from 32'h42, fetch_err=0.
